// File: rtl/alsu_cmd_driver.sv
// alsu_cmd_driver: queues ALSU command words, holds the ALSU pins for rep+1
// cycles, then returns the result and invalid flag as one response per command.
module alsu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [19:0]            cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [5:0]             rsp_data,
  output logic                   rsp_invalid,
  output logic [2:0]             drv_opcode,
  output logic [2:0]             drv_A,
  output logic [2:0]             drv_B,
  output logic                   drv_cin,
  output logic                   drv_red_op_A,
  output logic                   drv_red_op_B,
  output logic                   drv_bypass_A,
  output logic                   drv_bypass_B,
  output logic                   drv_direction,
  output logic                   drv_serial_in,
  input  logic [5:0]             alsu_out,
  input  logic [15:0]            alsu_leds,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(LATENCY + 1);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL1 = (AW+1)'(1);
  localparam logic [AW-1:0] PTR1 = AW'(1);
  localparam logic [WW-1:0] CNT1 = WW'(1);
  localparam logic [WW-1:0] LAT  = WW'(LATENCY);
  localparam logic [WW-1:0] LATM = WW'(LATENCY - 1);

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       red_a;
    logic       red_b;
    logic       byp_a;
    logic       byp_b;
    logic       dir;
    logic       sin;
  } pins_t;

  typedef enum logic [1:0] {
    IDLE, DRIVE, WAIT, RESP
  } state_t;

  logic [19:0]   mem [DEPTH];
  logic [19:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_nxt;
  pins_t         pins;
  logic [3:0]    hold_cnt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] lead_cnt;
  logic          inv_acc;
  logic          leds_hit;
  logic          sample;
  logic          load_wait;
  logic          capture;
  logic          rsp_done;

  assign cmd_ready = fifo_level != FULL;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = state != IDLE;
  assign leds_hit  = |alsu_leds;

  // leds are only meaningful once this command's pins have reached the ALSU
  assign sample = (state == DRIVE || state == WAIT) &&
                  lead_cnt == '0;

  assign drv_opcode    = pins.opcode;
  assign drv_A         = pins.a;
  assign drv_B         = pins.b;
  assign drv_cin       = pins.cin;
  assign drv_red_op_A  = pins.red_a;
  assign drv_red_op_B  = pins.red_b;
  assign drv_bypass_A  = pins.byp_a;
  assign drv_bypass_B  = pins.byp_b;
  assign drv_direction = pins.dir;
  assign drv_serial_in = pins.sin;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR1;
      if (pop)  rd_ptr <= rd_ptr + PTR1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL1;
        2'b01:   fifo_level <= fifo_level - LVL1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_wait = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          load_wait = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pins     <= '0;
      hold_cnt <= '0;
      wait_cnt <= '0;
      lead_cnt <= '0;
      inv_acc  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        pins     <= pins_t'(head[15:0]);
        hold_cnt <= head[19:16];
        lead_cnt <= LAT;
        inv_acc  <= 1'b0;
      end else begin
        if (load_wait) begin
          pins     <= '0;
          wait_cnt <= LATM;
        end
        if (state == DRIVE && hold_cnt != '0)
          hold_cnt <= hold_cnt - 4'd1;
        if (state == WAIT && wait_cnt != '0)
          wait_cnt <= wait_cnt - CNT1;
        if (busy && lead_cnt != '0)
          lead_cnt <= lead_cnt - CNT1;
        if (sample)
          inv_acc <= inv_acc | leds_hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_invalid <= 1'b0;
    end else if (capture) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= alsu_out;
      rsp_invalid <= inv_acc | leds_hit;
    end else if (rsp_done) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/alsu_cmd_driver.md
# alsu_cmd_driver

Command-side initiator for the ALSU. Accepts buffered command words over a valid/ready stream and drives the ALSU input pins for a programmed number of cycles. It waits out the ALSU pipeline latency, then captures `out` together with an invalid-operation flag and returns them as a response on a second valid/ready stream. Only one command is in flight at a time, which keeps shift/rotate state deterministic. Sits between a host or test sequencer and the ALSU instance.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `LATENCY`, 2: rising edges from a pin update to `alsu_out` reflecting it; ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command word present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_data`  in  20  command word:
  - [19:16] rep: pins held rep+1 cycles.
  - [15:13] opcode; [12:10] A; [9:7] B.
  - [6] cin; [5] red_op_A; [4] red_op_B; [3] bypass_A; [2] bypass_B; [1] direction; [0] serial_in.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  6  captured `alsu_out`.
- `rsp_invalid`  out  1  `alsu_leds` seen nonzero during the command's window.
- `drv_opcode` / `drv_A` / `drv_B`  out  3 each  to ALSU.
- `drv_cin`, `drv_red_op_A`, `drv_red_op_B`, `drv_bypass_A`, `drv_bypass_B`, `drv_direction`, `drv_serial_in`  out  1 each  to ALSU.
- `alsu_out`  in  6  from ALSU `out`.
- `alsu_leds`  in  16  from ALSU `leds`.
- `busy`  out  1  state ≠ IDLE.
- `fifo_level`  out  $clog2(DEPTH)+1  entries stored.

## Operation
- Reset value of every output is 0, except `cmd_ready` = 1. All `drv_*` are registered; their idle value is all-zero, which makes the ALSU produce `out`=0.
- FIFO:
  - Push when `cmd_valid & cmd_ready`. A push attempted while full is ignored.
  - Pop happens only in IDLE.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop on edge E0, load `drv_*` from the word, load the hold counter with rep, clear the sticky invalid flag, and go to DRIVE.
  - Otherwise stay.
- DRIVE:
  - While hold counter > 0, decrement it; pins stay constant.
  - At 0, on edge E0+rep+1: pins return to idle, load the wait counter with LATENCY−1, go to WAIT.
- WAIT:
  - Decrement the wait counter.
  - At 0, on edge E0+rep+LATENCY+1: capture `alsu_out` into `rsp_data`, set `rsp_valid`, go to RESP.
- Invalid flag: `rsp_invalid` is the OR of (`alsu_leds` ≠ 0) sampled on edges E0+LATENCY+1 through E0+rep+LATENCY+1 inclusive (rep+1 samples). It does not depend on the ALSU's led toggle parity.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_invalid` stable until `rsp_valid & rsp_ready`.
  - On that edge, clear `rsp_valid` and go to IDLE.
  - `rsp_data` and `rsp_invalid` keep their last values after the handshake.
- Responses are returned in command order, exactly one per command.
- Reset mid-operation: FIFO flushed, FSM to IDLE, pins idle, any pending response dropped.

## Timing
- Command accepted into an empty FIFO with FSM in IDLE: pop on the next edge (E0).
- Response valid at edge E0+rep+LATENCY+1.
- With `rsp_ready` held high, the command period is rep+LATENCY+3 cycles.
- The FIFO never pops while state ≠ IDLE.
- `cmd_ready` = (`fifo_level` ≠ DEPTH), combinational from the level.
- `alsu_out` and `alsu_leds` are sampled only on the edges stated above; all other edges are ignored.

## Test plan
All scenarios use LATENCY=2 with a real ALSU instance (priority A, full adder on).
- Add: opcode 2, A=5, B=3, cin=1, rep=0 → `rsp_valid` at edge E0+3, `rsp_data`=9, `rsp_invalid`=0.
- Multiply: opcode 3, A=7, B=7, rep=0 → `rsp_data`=49, `rsp_invalid`=0.
- Shift: opcode 4, direction=1, serial_in=1, rep=3, issued after an idle gap → `rsp_data`=6'b001111; response at E0+6.
- Invalid: opcode 6, rep=1 → `rsp_data`=0, `rsp_invalid`=1.
  - Repeat with rep=0 → `rsp_invalid`=1.
  - Follow with valid opcode 0, A=6, B=3 → `rsp_data`=2, `rsp_invalid`=0.
- Backpressure: DEPTH=4, `rsp_ready`=0, push 6 words back-to-back.
  - First word popped; next 4 stored, so `fifo_level`=4 and `cmd_ready`=0; 6th push ignored.
  - Raise `rsp_ready` → exactly 5 responses in order; `busy` falls after the last.
- Reset mid-DRIVE: rep=8 command, assert `rst` at E0+3 → all outputs 0, `fifo_level`=0, no response. A command issued after release behaves as after power-up.
